// File: rtl/seq_4bit_restoring_divider.sv
// seq_4bit_restoring_divider: 4-bit unsigned restoring divider, one quotient bit per clock, start/busy/done handshake
module seq_4bit_restoring_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [3:0] q, d, r;
  logic [1:0] cnt;
  logic [4:0] s, b, p, g, t;
  logic [4:0] c;
  logic qbit;
  logic [3:0] r_next, q_next;
  logic accept;
  // R never exceeds the divisor, so its top bit stays zero and only 4 bits are stored
  always_comb begin
    s = {r, q[3]};
    b = ~{1'b0, d};
    p = s ^ b;
    g = s & b;
    c[0] = 1'b1;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    t = p ^ c;
    qbit = ~t[4];
    r_next = qbit ? t[3:0] : s[3:0];
    q_next = {q[2:0], qbit};
    accept = start && state != CALC;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q <= '0;
      d <= '0;
      r <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        q <= dividend;
        d <= divisor;
        r <= '0;
        cnt <= 2'd3;
        if (divisor != 4'd0) begin
          state <= CALC;
          busy <= 1'b1;
        end else begin
          state <= DONE;
          done <= 1'b1;
          quotient <= 4'hF;
          remainder <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == CALC) begin
        r <= r_next;
        q <= q_next;
        cnt <= cnt - 2'd1;
        if (cnt == 2'd0) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          quotient <= q_next;
          remainder <= r_next;
          div_by_zero <= 1'b0;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seq_4bit_restoring_divider.sv
// tb_seq_4bit_restoring_divider: directed and exhaustive checks against an arithmetic latency model
module tb_seq_4bit_restoring_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic [3:0] quotient, remainder;
  logic busy, done, div_by_zero;
  int checks = 0, errors = 0;
  seq_4bit_restoring_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: a division takes 4 clocks after acceptance, divide-by-zero finishes immediately
  int rem = 0;
  logic [3:0] m_q = '0, m_r = '0, pq = '0, pr = '0;
  logic m_dz = 1'b0, m_done = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= 0; m_q <= '0; m_r <= '0; m_dz <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_done <= 1'b1; m_q <= pq; m_r <= pr; m_dz <= 1'b0;
        end
      end else if (start) begin
        if (divisor == 4'd0) begin
          m_done <= 1'b1; m_q <= 4'hF; m_r <= dividend; m_dz <= 1'b1;
        end else begin
          rem <= 4; pq <= dividend / divisor; pr <= dividend % divisor;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("busy", int'(busy), int'(rem > 0));
    chk("done", int'(done), int'(m_done));
    chk("quotient", int'(quotient), int'(m_q));
    chk("remainder", int'(remainder), int'(m_r));
    chk("div_by_zero", int'(div_by_zero), int'(m_dz));
  end
  task automatic run(input logic [3:0] a, input logic [3:0] b, input int eq, input int er,
                     input int edz, input int elat, input string nm);
    int n = 0, bc = 0;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) bc++;
    end while (!done && n < 20);
    chk({nm, " latency"}, n, elat);
    chk({nm, " busy_cycles"}, bc, elat - 1);
    chk({nm, " q"}, int'(quotient), eq);
    chk({nm, " r"}, int'(remainder), er);
    chk({nm, " dz"}, int'(div_by_zero), edz);
  endtask
  initial begin
    int dc, n;
    logic [3:0] a, b;
    repeat (3) @(negedge clk);
    chk("reset q", int'(quotient), 0);
    chk("reset busy", int'(busy), 0);
    rst_n = 1'b1;
    run(4'd13, 4'd3, 4, 1, 0, 5, "13/3");
    run(4'd15, 4'd1, 15, 0, 0, 5, "15/1");
    run(4'd5, 4'd7, 0, 5, 0, 5, "5/7");
    run(4'd0, 4'd9, 0, 0, 0, 5, "0/9");
    run(4'd9, 4'd0, 15, 9, 1, 1, "9/0");
    run(4'd8, 4'd2, 4, 0, 0, 5, "8/2");
    // a second start in the middle of a division must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; dividend = 4'd1; divisor = 4'd1;
    @(negedge clk); start = 1'b0;
    dc = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) begin
        dc++;
        chk("ignore q", int'(quotient), 3);
        chk("ignore r", int'(remainder), 2);
      end
    end
    chk("ignore done_count", dc, 1);
    // asynchronous reset in the middle of a division
    @(negedge clk);
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset q", int'(quotient), 0);
    chk("areset r", int'(remainder), 0);
    chk("areset busy", int'(busy), 0);
    dc = 0;
    repeat (3) begin @(negedge clk); dc += int'(done); end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); dc += int'(done); end
    chk("areset done_count", dc, 0);
    run(4'd11, 4'd2, 5, 1, 0, 5, "11/2");
    // every operand pair back to back with start held high
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = 4'(i >> 4); b = 4'(i);
      dividend = a; divisor = b;
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 20);
      chk("b2b latency", n, b == 0 ? 1 : 5);
      chk("b2b q", int'(quotient), b == 0 ? 15 : int'(a) / int'(b));
      chk("b2b r", int'(remainder), b == 0 ? int'(a) : int'(a) % int'(b));
      chk("b2b dz", int'(div_by_zero), int'(b == 0));
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
